// File: rtl/ifetch_line_responder_if.sv
// Fetch-side request/response and physical-memory line-read handshake bundle.
// The responder takes the slave view and the requester/memory side takes the master view.
interface ifetch_line_responder_if;
  logic         mem_request;
  logic [15:0]  mem_address;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  modport slave (
    input  mem_request, mem_address, pmem_resp, pmem_rdata,
    output mem_resp, mem_rdata, pmem_read, pmem_address
  );

  modport master (
    output mem_request, mem_address, pmem_resp, pmem_rdata,
    input  mem_resp, mem_rdata, pmem_read, pmem_address
  );
endinterface

// File: rtl/ifetch_line_responder.sv
// Single-line (8 x 16-bit) instruction buffer that answers fetch requests and
// refills itself from physical memory on a miss, with saturating hit/miss statistics.
module ifetch_line_responder #(
  parameter int STAT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  ifetch_line_responder_if.slave    bus,
  output logic [STAT_WIDTH-1:0]     hit_count,
  output logic [STAT_WIDTH-1:0]     miss_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic [15:0] line_word(input logic [127:0] line, input logic [2:0] off);
    line_word = line[{off, 4'b0000} +: 16];
  endfunction

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    if (v == {STAT_WIDTH{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e                  state_q, state_d;
  logic                    valid_q, valid_d;
  logic [11:0]             tag_q, tag_d;
  logic [127:0]            line_q, line_d;
  logic [11:0]             lat_tag_q, lat_tag_d;
  logic [2:0]              lat_off_q, lat_off_d;
  logic                    fill_flush_q, fill_flush_d;
  logic                    mem_resp_q, mem_resp_d;
  logic [15:0]             mem_rdata_q, mem_rdata_d;
  logic                    pmem_read_q, pmem_read_d;
  logic [15:0]             pmem_address_q, pmem_address_d;
  logic [STAT_WIDTH-1:0]   hit_q, hit_d;
  logic [STAT_WIDTH-1:0]   miss_q, miss_d;

  logic [11:0]             req_tag_s;
  logic [2:0]              req_off_s;
  logic                    hit_s;

  // A flush arriving with a request forces the miss path.
  assign req_tag_s = bus.mem_address[15:4];
  assign req_off_s = bus.mem_address[3:1];
  assign hit_s     = valid_q && (tag_q == req_tag_s) && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_request) begin
          state_d = hit_s ? S_RESP : S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (bus.pmem_resp) begin
          state_d = bus.mem_request ? S_RESP : S_IDLE;
        end else begin
          state_d = S_FILL;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    valid_d        = valid_q;
    tag_d          = tag_q;
    line_d         = line_q;
    lat_tag_d      = lat_tag_q;
    lat_off_d      = lat_off_q;
    fill_flush_d   = fill_flush_q;
    mem_resp_d     = 1'b0;
    mem_rdata_d    = mem_rdata_q;
    pmem_read_d    = pmem_read_q;
    pmem_address_d = pmem_address_q;
    hit_d          = hit_q;
    miss_d         = miss_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
        if (bus.mem_request && hit_s) begin
          mem_rdata_d = line_word(line_q, req_off_s);
          mem_resp_d  = 1'b1;
          hit_d       = sat_inc(hit_q);
        end else if (bus.mem_request) begin
          lat_tag_d      = req_tag_s;
          lat_off_d      = req_off_s;
          pmem_address_d = {req_tag_s, 4'b0000};
          pmem_read_d    = 1'b1;
          fill_flush_d   = 1'b0;
          miss_d         = sat_inc(miss_q);
        end else begin
          mem_resp_d = 1'b0;
        end
      end
      S_FILL: begin
        if (bus.pmem_resp) begin
          pmem_read_d = 1'b0;
          line_d      = bus.pmem_rdata;
          tag_d       = lat_tag_q;
          valid_d     = !(fill_flush_q || flush);
          if (bus.mem_request) begin
            mem_rdata_d = line_word(bus.pmem_rdata, lat_off_q);
            mem_resp_d  = 1'b1;
          end else begin
            mem_resp_d  = 1'b0;
          end
        end else begin
          fill_flush_d = fill_flush_q | flush;
        end
      end
      S_RESP: begin
        if (flush) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q        <= 1'b0;
      tag_q          <= 12'h000;
      line_q         <= 128'h0;
      lat_tag_q      <= 12'h000;
      lat_off_q      <= 3'd0;
      fill_flush_q   <= 1'b0;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= 16'h0000;
      pmem_read_q    <= 1'b0;
      pmem_address_q <= 16'h0000;
      hit_q          <= {STAT_WIDTH{1'b0}};
      miss_q         <= {STAT_WIDTH{1'b0}};
    end else begin
      valid_q        <= valid_d;
      tag_q          <= tag_d;
      line_q         <= line_d;
      lat_tag_q      <= lat_tag_d;
      lat_off_q      <= lat_off_d;
      fill_flush_q   <= fill_flush_d;
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_address_q <= pmem_address_d;
      hit_q          <= hit_d;
      miss_q         <= miss_d;
    end
  end

  assign bus.mem_resp     = mem_resp_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_address = pmem_address_q;
  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

endmodule

// File: tb/tb_ifetch_line_responder.sv
// Directed bench for ifetch_line_responder: a 16-bit-counter instance for the
// functional scenarios and a 2-bit-counter instance for saturation.
module tb_ifetch_line_responder;

  logic clk;
  logic reset;
  logic flush;
  logic flush2;
  logic [15:0] hit_count, miss_count;
  logic [1:0]  hit2, miss2;
  int checks;
  int errors;
  int resp2_cnt;

  ifetch_line_responder_if bus ();
  ifetch_line_responder_if bus2 ();

  ifetch_line_responder #(.STAT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  ifetch_line_responder #(.STAT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush2), .bus(bus2),
    .hit_count(hit2), .miss_count(miss2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus2.mem_resp === 1'b1) resp2_cnt = resp2_cnt + 1;
  end

  function automatic logic [127:0] mk_line(input logic [15:0] base);
    logic [127:0] l;
    l = 128'h0;
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = base + 16'(i);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL rst_resp got %h exp 0", bus.mem_resp); end
    checks++; if (bus.mem_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h exp 0000", bus.mem_rdata); end
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL rst_pread got %h exp 0", bus.pmem_read); end
    checks++; if (bus.pmem_address !== 16'h0000) begin errors++; $display("FAIL rst_paddr got %h exp 0000", bus.pmem_address); end
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", hit_count, miss_count); end
  endtask

  task automatic test_cold_miss();
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h3006;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) bus.mem_address = 16'h1234;
      checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h3000) begin errors++; $display("FAIL cold_pread cyc %0d got %h/%h exp 1/3000", c, bus.pmem_read, bus.pmem_address); end
      checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL cold_early_resp cyc %0d got %h exp 0", c, bus.mem_resp); end
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(16'h0000);
    tick();
    bus.pmem_resp   = 1'b0;
    bus.mem_request = 1'b0;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 16'h0003) begin errors++; $display("FAIL cold_resp got %h/%h exp 1/0003", bus.mem_resp, bus.mem_rdata); end
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL cold_pread_drop got %h exp 0", bus.pmem_read); end
    tick();
    checks++; if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== 16'h0003) begin errors++; $display("FAIL cold_single got %h/%h exp 0/0003", bus.mem_resp, bus.mem_rdata); end
    checks++; if (miss_count !== 16'd1 || hit_count !== 16'd0) begin errors++; $display("FAIL cold_counts got %0d/%0d exp 0/1", hit_count, miss_count); end
  endtask

  task automatic test_hit();
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h300E;
    tick();
    bus.mem_request = 1'b0;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 16'h0007) begin errors++; $display("FAIL hit_resp got %h/%h exp 1/0007", bus.mem_resp, bus.mem_rdata); end
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL hit_pread got %h exp 0", bus.pmem_read); end
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL hit_count got %0d exp 1", hit_count); end
    tick();
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL hit_single got %h exp 0", bus.mem_resp); end
  endtask

  task automatic test_tag_change();
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h4002;
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h4000) begin errors++; $display("FAIL tag_pread got %h/%h exp 1/4000", bus.pmem_read, bus.pmem_address); end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(16'h4000);
    tick();
    bus.pmem_resp   = 1'b0;
    bus.mem_request = 1'b0;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 16'h4001) begin errors++; $display("FAIL tag_resp got %h/%h exp 1/4001", bus.mem_resp, bus.mem_rdata); end
    tick();
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h3000;
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h3000 || bus.mem_resp !== 1'b0) begin errors++; $display("FAIL tag_remiss got %h/%h/%h exp 1/3000/0", bus.pmem_read, bus.pmem_address, bus.mem_resp); end
    checks++; if (miss_count !== 16'd3) begin errors++; $display("FAIL tag_miss_count got %0d exp 3", miss_count); end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(16'h3000);
    tick();
    bus.pmem_resp   = 1'b0;
    bus.mem_request = 1'b0;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 16'h3000) begin errors++; $display("FAIL tag_refill got %h/%h exp 1/3000", bus.mem_resp, bus.mem_rdata); end
    tick();
  endtask

  task automatic test_flush_fill();
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h5000;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h5000) begin errors++; $display("FAIL flush_pread got %h/%h exp 1/5000", bus.pmem_read, bus.pmem_address); end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(16'h5000);
    tick();
    bus.pmem_resp   = 1'b0;
    bus.mem_request = 1'b0;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 16'h5000) begin errors++; $display("FAIL flush_resp got %h/%h exp 1/5000", bus.mem_resp, bus.mem_rdata); end
    tick();
    bus.mem_request = 1'b1;
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.mem_resp !== 1'b0) begin errors++; $display("FAIL flush_remiss got %h/%h exp 1/0", bus.pmem_read, bus.mem_resp); end
    checks++; if (miss_count !== 16'd5) begin errors++; $display("FAIL flush_miss_count got %0d exp 5", miss_count); end
  endtask

  task automatic test_withdraw();
    // continues the fill of 0x5000 started above, with the request withdrawn
    bus.mem_request = 1'b0;
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(16'h5000);
    tick();
    bus.pmem_resp = 1'b0;
    checks++; if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL wd_noresp got %h/%h exp 0/0", bus.mem_resp, bus.pmem_read); end
    tick();
    checks++; if (bus.mem_resp !== 1'b0) begin errors++; $display("FAIL wd_noresp2 got %h exp 0", bus.mem_resp); end
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h5004;
    tick();
    bus.mem_request = 1'b0;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 16'h5002 || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL wd_hit got %h/%h/%h exp 1/5002/0", bus.mem_resp, bus.mem_rdata, bus.pmem_read); end
    checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL wd_hit_count got %0d exp 2", hit_count); end
    tick();
  endtask

  task automatic test_flush_idle();
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h5002;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (bus.pmem_read !== 1'b1 || bus.mem_resp !== 1'b0 || miss_count !== 16'd6) begin errors++; $display("FAIL fidle_miss got %h/%h/%0d exp 1/0/6", bus.pmem_read, bus.mem_resp, miss_count); end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(16'h5000);
    tick();
    bus.pmem_resp   = 1'b0;
    bus.mem_request = 1'b0;
    checks++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 16'h5001) begin errors++; $display("FAIL fidle_resp got %h/%h exp 1/5001", bus.mem_resp, bus.mem_rdata); end
    tick();
  endtask

  task automatic test_reset_fill();
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h6000;
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h6000) begin errors++; $display("FAIL rfill_pread got %h/%h exp 1/6000", bus.pmem_read, bus.pmem_address); end
    reset = 1'b1;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(16'h6000);
    tick();
    reset = 1'b0;
    bus.pmem_resp   = 1'b0;
    bus.mem_request = 1'b0;
    checks++; if (bus.pmem_read !== 1'b0 || bus.mem_resp !== 1'b0 || miss_count !== 16'd0) begin errors++; $display("FAIL rfill_abort got %h/%h/%0d exp 0/0/0", bus.pmem_read, bus.mem_resp, miss_count); end
    tick();
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    checks++; if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL rfill_stray got %h/%h exp 0/0", bus.mem_resp, bus.pmem_read); end
    bus.mem_request = 1'b1;
    bus.mem_address = 16'h6000;
    tick();
    checks++; if (bus.pmem_read !== 1'b1 || bus.mem_resp !== 1'b0 || miss_count !== 16'd1) begin errors++; $display("FAIL rfill_invalid got %h/%h/%0d exp 1/0/1", bus.pmem_read, bus.mem_resp, miss_count); end
    bus.mem_request = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus2.mem_request = 1'b1;
    bus2.mem_address = 16'h1002;
    tick();
    bus2.pmem_resp  = 1'b1;
    bus2.pmem_rdata = mk_line(16'h1000);
    tick();
    bus2.pmem_resp   = 1'b0;
    bus2.mem_request = 1'b0;
    checks++; if (bus2.mem_resp !== 1'b1 || bus2.mem_rdata !== 16'h1001) begin errors++; $display("FAIL b2b_fill got %h/%h exp 1/1001", bus2.mem_resp, bus2.mem_rdata); end
    tick();
    for (int i = 0; i < 5; i++) begin
      bus2.mem_request = 1'b1;
      bus2.mem_address = 16'h1000 + 16'(2 * i);
      tick();
      bus2.mem_request = 1'b0;
      checks++; if (bus2.mem_resp !== 1'b1 || bus2.mem_rdata !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL b2b_hit %0d got %h/%h exp 1/%h", i, bus2.mem_resp, bus2.mem_rdata, 16'h1000 + 16'(i)); end
      tick();
      checks++; if (bus2.mem_resp !== 1'b0) begin errors++; $display("FAIL b2b_single %0d got %h exp 0", i, bus2.mem_resp); end
    end
    tick();
    checks++; if (hit2 !== 2'd3) begin errors++; $display("FAIL sat_hit got %0d exp 3", hit2); end
    checks++; if (miss2 !== 2'd1) begin errors++; $display("FAIL sat_miss got %0d exp 1", miss2); end
    checks++; if (resp2_cnt !== 6) begin errors++; $display("FAIL b2b_resp_count got %0d exp 6", resp2_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resp2_cnt = 0;
    reset = 1'b1;
    flush = 1'b0;
    flush2 = 1'b0;
    bus.mem_request = 1'b0;
    bus.mem_address = 16'h0000;
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = 128'h0;
    bus2.mem_request = 1'b0;
    bus2.mem_address = 16'h0000;
    bus2.pmem_resp = 1'b0;
    bus2.pmem_rdata = 128'h0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_tag_change();
    test_flush_fill();
    test_withdraw();
    test_flush_idle();
    test_reset_fill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_line_responder.md
Name: ifetch_line_responder

Overview:
- Responder end of the fetch-stage instruction memory handshake (mem_request / mem_resp).
- Serves 16-bit instruction reads from a single 8-word (128-bit) line buffer.
- On a miss, fetches the whole line from physical memory via a pmem_read / pmem_resp handshake, installs it, then answers the requester.
- Sits between the IF/ID stage and the physical memory port.

Parameters:
- STAT_WIDTH, 16, width of the saturating hit and miss counters.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_request  input  1  level request from fetch stage; held high until mem_resp is seen.
- mem_address  input  16  byte address of the instruction (lc3b_word); bit 0 ignored.
- flush  input  1  invalidates the line buffer.
- mem_resp  output  1  one-cycle pulse: mem_rdata is valid.
- mem_rdata  output  16  instruction word (lc3b_word).
- pmem_read  output  1  line read request to physical memory; held until pmem_resp.
- pmem_address  output  16  line-aligned address {tag, 4'b0000}.
- pmem_resp  input  1  one-cycle pulse: pmem_rdata is valid.
- pmem_rdata  input  128  line data; word i at bits [16i+15:16i].
- hit_count  output  STAT_WIDTH  saturating count of requests served from the buffer.
- miss_count  output  STAT_WIDTH  saturating count of line fills started.

Behaviour:
- Address split: tag = addr[15:4], word offset = addr[3:1].
- Hit condition: valid && stored tag == addr[15:4].
- Reset values:
  - State IDLE; valid = 0; tag = 0; line = 0.
  - mem_resp = 0, mem_rdata = 0, pmem_read = 0, pmem_address = 0.
  - hit_count = 0, miss_count = 0.
  - Reset wins over every other input in the same cycle.
- IDLE:
  - mem_request && hit: register line word [offset] into mem_rdata; hit_count++ (saturating); go to RESP. Latency from request to mem_resp is 1 cycle.
  - mem_request && !hit: latch the request address; pmem_address = {addr[15:4], 4'b0}; pmem_read = 1; miss_count++ (saturating); go to FILL.
  - Otherwise stay in IDLE.
- FILL:
  - pmem_read and pmem_address held stable until pmem_resp.
  - On pmem_resp: pmem_read drops in the next cycle; line <= pmem_rdata; tag <= latched tag.
  - If mem_request is still high: valid <= 1; mem_rdata <= pmem_rdata word [latched offset]; go to RESP.
  - If mem_request has dropped: valid <= 1; install the line but issue no response; go to IDLE.
  - mem_address changes during FILL are ignored; the latched address governs.
- RESP:
  - mem_resp = 1 for exactly one cycle; mem_rdata is held until the next response.
  - Unconditionally return to IDLE; a request still high in the RESP cycle is not re-served.
  - The requester drops mem_request on the same edge it samples mem_resp, so no duplicate response is issued.
- flush:
  - In IDLE or RESP: valid <= 0 next cycle.
  - Coinciding with a request in IDLE: treat the request as a miss.
  - During FILL, or coinciding with pmem_resp: the fill completes and the requester still gets its word, but valid stays 0, so the next access misses.
- pmem_resp outside FILL is ignored.
- Reset mid-FILL: abandon the fill; pmem_read = 0 on the next cycle; a later stray pmem_resp is ignored.
- Counters stick at 2^STAT_WIDTH - 1.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, request 0x3006; pmem returns line 0x..._0004_0003_0002_0001_0000 (word i = i) after 5 cycles.
   - Required: pmem_address = 0x3000 held high 5 cycles; mem_resp pulses once with mem_rdata = 0x0003; miss_count = 1.
2. Hit:
   - Stimulus: request 0x300E right after scenario 1.
   - Required: mem_resp one cycle later, mem_rdata = 0x0007; no pmem_read; hit_count = 1.
3. Tag change:
   - Stimulus: request 0x4002.
   - Required: pmem_read with pmem_address = 0x4000; afterwards, a request to 0x3000 misses again.
4. Flush during FILL:
   - Stimulus: assert flush mid-fill of 0x5000.
   - Required: response still delivered; the following request to 0x5000 issues a new pmem_read; miss_count increments.
5. Request withdrawn / reset mid-fill:
   - Stimulus A: drop mem_request during FILL. Required: no mem_resp; line installed; a later 0x5000 request hits in 1 cycle.
   - Stimulus B: reset during FILL, then a stray pmem_resp. Required: pmem_read = 0, no mem_resp, valid = 0.
6. Saturation and handshake integrity:
   - Stimulus: STAT_WIDTH = 2; five hits.
   - Required: hit_count = 3; exactly one mem_resp per request across back-to-back requests.
